// File: rtl/cpuid_req_arbiter.sv
// ---------------------------------------------------------------------------
// cpuid_req_arbiter
//
// Purpose:
//   Shares a single combinational CPUID leaf model between NUM_REQ requesters
//   (per-core CSR CPUID windows, debug port). Requests are arbitrated
//   round-robin. The winning leaf/subleaf is presented to the model from
//   registers, the four 64-bit result lanes are captured one cycle later,
//   and they are returned on the winner's response handshake.
//
//   Transaction timeline:
//     T    : IDLE, req_ready[g]=1 (combinational), leaf/subleaf registered
//     T+1  : LOOKUP, model inputs stable, result lanes captured at the edge
//     T+2..: RESP, rsp_valid[g]=1 until rsp_ready[g]
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   req_valid / req_ready    per-requester request handshake (ready one-hot)
//   req_leaf / req_subleaf   packed per-requester leaf/subleaf, 32 bits each
//   rsp_valid / rsp_ready    per-requester response handshake (valid one-hot)
//   rsp_data0..3             captured result lanes, shared by all requesters
//   rsp_known                captured leaf <= MAX_STD_LEAF
//   cpuid_leaf/_subleaf      registered inputs to the leaf model
//   cpuid_data0..3           combinational result lanes from the leaf model
//   busy                     a transaction is in flight (LOOKUP or RESP)
// ---------------------------------------------------------------------------
module cpuid_req_arbiter #(
    parameter int          NUM_REQ      = 2,
    parameter logic [31:0] MAX_STD_LEAF = 32'h0000_0005
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_leaf,
    input  logic [NUM_REQ*32-1:0]   req_subleaf,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [63:0]             rsp_data0,
    output logic [63:0]             rsp_data1,
    output logic [63:0]             rsp_data2,
    output logic [63:0]             rsp_data3,
    output logic                    rsp_known,
    output logic [31:0]             cpuid_leaf,
    output logic [31:0]             cpuid_subleaf,
    input  logic [63:0]             cpuid_data0,
    input  logic [63:0]             cpuid_data1,
    input  logic [63:0]             cpuid_data2,
    input  logic [63:0]             cpuid_data3,
    output logic                    busy
);

    // Index width; a single requester still needs one bit to hold index 0.
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Index of the lowest set bit; 0 when the vector is empty (callers
    // only use the result when some bit is set).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_REQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = vec[i] ? IDX_W'(i) : idx;
        end
        return idx;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            vec[i] = (idx == IDX_W'(i));
        end
        return vec;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_gnt;
    logic [31:0]        r_leaf;
    logic [31:0]        r_subleaf;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [63:0]        r_rsp_data0;
    logic [63:0]        r_rsp_data1;
    logic [63:0]        r_rsp_data2;
    logic [63:0]        r_rsp_data3;
    logic               r_rsp_known;
    logic               r_busy;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_above_mask;
    logic [NUM_REQ-1:0] w_hi_req;
    logic               w_any_req;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_accept;
    logic [31:0]        w_sel_leaf;
    logic [31:0]        w_sel_subleaf;
    logic               w_rsp_take;

    // Requesters strictly above the pointer get first pick; the search
    // then wraps to index 0. With NUM_REQ=1 the mask is always empty and
    // requester 0 wins through the wrap path.
    always_comb begin
        w_above_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_above_mask[i] = (IDX_W'(i) > r_rr_ptr);
        end
    end

    assign w_hi_req  = req_valid & w_above_mask;
    assign w_any_req = |req_valid;
    assign w_gnt_idx = (|w_hi_req) ? lowest_set(w_hi_req) : lowest_set(req_valid);

    // Accept only in IDLE; rst also masks it so req_ready is 0 while reset
    // is held even though the state register already reads IDLE.
    assign w_accept = (r_state == ST_IDLE) && w_any_req && !rst;

    // Grant decode and leaf/subleaf mux for the winning requester.
    always_comb begin
        req_ready     = '0;
        w_sel_leaf    = 32'h0000_0000;
        w_sel_subleaf = 32'h0000_0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i]  = w_accept && (w_gnt_idx == IDX_W'(i));
            w_sel_leaf    = (w_gnt_idx == IDX_W'(i)) ? req_leaf[32*i +: 32]    : w_sel_leaf;
            w_sel_subleaf = (w_gnt_idx == IDX_W'(i)) ? req_subleaf[32*i +: 32] : w_sel_subleaf;
        end
    end

    // rsp_valid is one-hot on the granted requester, so ANDing with
    // rsp_ready ignores the ready lines of every other requester.
    assign w_rsp_take = |(r_rsp_valid & rsp_ready);

    // -----------------------------------------------------------------------
    // Transaction FSM with registered outputs
    // -----------------------------------------------------------------------

    // IDLE -> LOOKUP -> RESP -> IDLE; leaf/subleaf registers change only at
    // accept so the model inputs stay glitch-free across the lookup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
            r_gnt       <= '0;
            r_leaf      <= 32'h0000_0000;
            r_subleaf   <= 32'h0000_0000;
            r_rsp_valid <= '0;
            r_rsp_data0 <= 64'h0;
            r_rsp_data1 <= 64'h0;
            r_rsp_data2 <= 64'h0;
            r_rsp_data3 <= 64'h0;
            r_rsp_known <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_leaf    <= w_sel_leaf;
                        r_subleaf <= w_sel_subleaf;
                        r_gnt     <= w_gnt_idx;
                        r_rr_ptr  <= w_gnt_idx;
                        r_busy    <= 1'b1;
                        r_state   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_rsp_data0 <= cpuid_data0;
                    r_rsp_data1 <= cpuid_data1;
                    r_rsp_data2 <= cpuid_data2;
                    r_rsp_data3 <= cpuid_data3;
                    r_rsp_known <= (r_leaf <= MAX_STD_LEAF);
                    r_rsp_valid <= to_onehot(r_gnt);
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    // No timeout: hold the response until the owner takes it.
                    if (w_rsp_take) begin
                        r_rsp_valid <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    r_rsp_valid <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data0     = r_rsp_data0;
    assign rsp_data1     = r_rsp_data1;
    assign rsp_data2     = r_rsp_data2;
    assign rsp_data3     = r_rsp_data3;
    assign rsp_known     = r_rsp_known;
    assign cpuid_leaf    = r_leaf;
    assign cpuid_subleaf = r_subleaf;
    assign busy          = r_busy;

endmodule
